// File: rtl/ks_pkg.sv
// ks_pkg: shared width and skid-buffer state encoding for the Kogge-Stone sum stage
package ks_pkg;
    localparam int KS_WIDTH = 24;
    typedef enum logic [1:0] {EMPTY, HALF, FULL} ks_state_e;
endpackage

// File: rtl/ks_sum.sv
// ks_sum: final Kogge-Stone sum from saved propagates and group generates
module ks_sum #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] p_save,
    input  logic [WIDTH-1:0] gk,
    input  logic             c0,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    always_comb begin
        sum  = p_save ^ {gk[WIDTH-2:0], c0};
        cout = gk[WIDTH-1];
    end
endmodule

// File: rtl/ks_sum_pipe.sv
// ks_sum_pipe: registered Kogge-Stone sum stage behind a 2-entry skid buffer
module ks_sum_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_c0,
    input  logic [WIDTH-1:0] i_gk,
    input  logic [WIDTH-1:0] i_p_save,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;
    logic [WIDTH:0]   main_q, main_d, skid_q, skid_d;
    logic             acc, del;
    ks_state_e        state_q, state_d;
    ks_sum #(.WIDTH(WIDTH)) u_sum (
        .p_save(i_p_save),
        .gk    (i_gk),
        .c0    (i_c0),
        .sum   (in_sum),
        .cout  (in_cout)
    );
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= EMPTY;
        else       state_q <= state_d;
    end
    always_comb begin
        acc     = i_valid && o_ready;
        del     = o_valid && i_ready;
        state_d = state_q;
        unique case (state_q)
            EMPTY:   state_d = acc ? HALF : EMPTY;
            HALF:    state_d = (acc && !del) ? FULL : (!acc && del) ? EMPTY : HALF;
            FULL:    state_d = del ? HALF : FULL;
            default: state_d = EMPTY;
        endcase
        if (i_flush) state_d = EMPTY;
    end
    always_comb begin
        o_valid = state_q != EMPTY;
        o_ready = state_q != FULL;
        o_sum   = main_q[WIDTH-1:0];
        o_cout  = main_q[WIDTH];
    end
    // entries keep their contents on flush so o_sum/o_cout hold while idle
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (!i_flush) begin
            unique case (state_q)
                EMPTY:   main_d = acc ? {in_cout, in_sum} : main_q;
                HALF: begin
                    main_d = (acc && del) ? {in_cout, in_sum} : main_q;
                    skid_d = (acc && !del) ? {in_cout, in_sum} : skid_q;
                end
                FULL:    main_d = del ? skid_q : main_q;
                default: main_d = main_q;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end
endmodule

// File: tb/tb_ks_sum_pipe.sv
// tb_ks_sum_pipe: random and directed checks of ks_sum_pipe against an a+b+c0 FIFO model
module tb_ks_sum_pipe;
    localparam int W = 24;
    logic         i_clk = 0, i_rst = 1, i_valid = 0, i_c0 = 0, i_flush = 0, i_ready = 0;
    logic [W-1:0] i_gk = '0, i_p_save = '0;
    logic         o_ready, o_valid, o_cout;
    logic [W-1:0] o_sum;
    logic [W:0]   cur_exp = '0, hold = '0;
    logic [W:0]   q[$];
    logic         chk_en = 0, acc, del;
    int           n_chk = 0, n_fail = 0;
    logic [W-1:0] ra, rb, va, vb, vc;
    ks_sum_pipe #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_c0(i_c0), .i_gk(i_gk), .i_p_save(i_p_save), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout)
    );
    always #5 i_clk = ~i_clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [W-1:0] gk_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W-1:0]    r;
        longint unsigned m, s;
        for (int k = 0; k < W; k++) begin
            m    = (64'd1 << (k + 1)) - 1;
            s    = (a & m) + (b & m) + c;
            r[k] = s[k+1];
        end
        return r;
    endfunction
    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        i_p_save = a ^ b;
        i_gk     = gk_of(a, b, c);
        i_c0     = c;
        cur_exp  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endtask
    task automatic raw(input logic [W-1:0] p, input logic [W-1:0] g, input logic c, input logic [W:0] e);
        i_p_save = p;
        i_gk     = g;
        i_c0     = c;
        cur_exp  = e;
    endtask
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask
    task automatic rnd_beat();
        beat(W'($urandom), W'($urandom), 1'($urandom));
    endtask
    // model state after the coming edge; outputs checked mid-cycle against it
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("o_valid", o_valid, q.size() != 0);
            check("o_ready", o_ready, q.size() < 2);
            check("o_cout_sum", {o_cout, o_sum}, q.size() != 0 ? q[0] : hold);
        end
        acc = i_valid && q.size() < 2;
        del = q.size() != 0 && i_ready;
        if (i_rst) begin
            q.delete();
            hold = '0;
        end else if (i_flush) begin
            if (q.size() != 0) hold = q[0];
            q.delete();
        end else begin
            if (del) begin
                hold = q[0];
                void'(q.pop_front());
            end
            if (acc) q.push_back(cur_exp);
            if (q.size() != 0) hold = q[0];
        end
    end
    initial begin
        check("gk_pin", gk_of(24'hFFFFFF, 24'h000001, 1'b0), 24'hFFFFFF);
        check("gk_pin_c0", gk_of(24'h000001, 24'h000000, 1'b1), 24'h000001);
        cyc();
        cyc();
        chk_en = 1;
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_sum", {o_cout, o_sum}, 0);
        i_rst = 0;
        i_ready = 1;
        i_valid = 1;
        beat(24'hFFFFFF, 24'h000001, 0);
        check("pin_psave", i_p_save, 24'hFFFFFE);
        cyc();
        check("wrap_valid", o_valid, 1);
        check("wrap_sum", o_sum, 0);
        check("wrap_cout", o_cout, 1);
        raw(24'h000003, 24'h000000, 0, 25'h3);
        cyc();
        check("raw_c0_0", {o_cout, o_sum}, 25'h000003);
        raw(24'h000003, 24'h000000, 1, 25'h2);
        cyc();
        check("raw_c0_1", {o_cout, o_sum}, 25'h000002);
        i_valid = 0;
        cyc();
        check("drain_valid", o_valid, 0);
        i_ready = 0;
        i_valid = 1;
        va = 24'h111111; vb = 24'h222222; vc = 24'h333333;
        beat(va, 0, 0);
        cyc();
        beat(vb, 0, 0);
        cyc();
        beat(vc, 0, 0);
        check("bp_full_ready", o_ready, 0);
        check("bp_hold_a", o_sum, va);
        cyc();
        cyc();
        check("bp_still_a", o_sum, va);
        i_ready = 1;
        cyc();
        check("bp_b", o_sum, vb);
        cyc();
        check("bp_c", o_sum, vc);
        i_valid = 0;
        cyc();
        check("bp_empty", o_valid, 0);
        i_ready = 0;
        i_valid = 1;
        beat(24'h0A0A0A, 24'h050505, 0);
        cyc();
        beat(24'h123456, 24'h654321, 1);
        cyc();
        beat(24'hDEAD00, 24'h00BEEF, 0);
        i_flush = 1;
        cyc();
        check("flush_valid", o_valid, 0);
        check("flush_ready", o_ready, 1);
        i_flush = 0;
        i_valid = 0;
        i_ready = 1;
        repeat (3) cyc();
        check("flush_nodeliver", o_valid, 0);
        i_ready = 0;
        i_valid = 1;
        rnd_beat();
        cyc();
        rnd_beat();
        cyc();
        i_rst = 1;
        cyc();
        check("rst_full_valid", o_valid, 0);
        check("rst_full_ready", o_ready, 1);
        check("rst_full_sum", {o_cout, o_sum}, 0);
        i_rst = 0;
        i_ready = 1;
        beat(24'hABCDEF, 24'h543210, 1);
        cyc();
        check("post_rst_beat", {o_cout, o_sum}, 25'h1000000);
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            beat(ra, rb, 1'(i));
            cyc();
            check("stream", {o_cout, o_sum}, {1'b0, ra} + {1'b0, rb} + 25'(i % 2));
        end
        for (int i = 0; i < 600; i++) begin
            i_valid = 1'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 40) == 0);
            i_rst   = ($urandom_range(0, 80) == 0);
            rnd_beat();
            cyc();
        end
        i_valid = 0;
        i_flush = 0;
        i_rst = 0;
        i_ready = 1;
        repeat (4) cyc();
        @(negedge i_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ks_sum_pipe.md
KS_SUM_PIPE -- requirements
Module: ks_sum_pipe

Interface
REQ-001 Parameter: WIDTH, default 24, operand/sum width in bits; all vectors below are WIDTH wide unless stated.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_valid  input  1  upstream beat valid (last Kogge-Stone prefix stage output).
REQ-005 o_ready  output  1  block can accept a beat this cycle.
REQ-006 i_c0  input  1  adder carry-in forwarded through the prefix tree.
REQ-007 i_gk  input  WIDTH  final group generates; i_gk[k] = carry out of bit k including carry-in.
REQ-008 i_p_save  input  WIDTH  bitwise propagates (a^b) saved from the PG stage.
REQ-009 i_flush  input  1  drop all buffered beats.
REQ-010 o_valid  output  1  sum beat valid.
REQ-011 i_ready  input  1  downstream accepts the beat.
REQ-012 o_sum  output  WIDTH  adder sum.
REQ-013 o_cout  output  1  adder carry-out.

Function
REQ-014 Carry vector: c[0] = i_c0; c[k] = i_gk[k-1] for 1 <= k <= WIDTH-1.
REQ-015 Sum: o_sum bit k = i_p_save[k] XOR c[k]; o_cout = i_gk[WIDTH-1]; no truncation or extension, result exactly WIDTH+1 bits.
REQ-016 Accept occurs when i_valid && o_ready; deliver occurs when o_valid && i_ready.
REQ-017 Storage: 2-entry skid buffer (main register + skid register), each entry holding {sum, cout}.
REQ-018 State machine: EMPTY (0 entries), HALF (1 entry), FULL (2 entries).
REQ-019 EMPTY: o_valid=0, o_ready=1; accept -> HALF.
REQ-020 HALF: o_valid=1, o_ready=1; accept without deliver -> FULL; deliver without accept -> EMPTY; accept and deliver together -> HALF, new beat replaces main entry.
REQ-021 FULL: o_valid=1, o_ready=0; deliver -> HALF, skid entry moves to main entry; no accept possible.
REQ-022 Latency: a beat accepted at edge N is presented on o_sum/o_cout with o_valid=1 in cycle N+1 if buffer was EMPTY, or in HALF with simultaneous deliver.
REQ-023 Ordering strictly FIFO; no beat dropped or duplicated except by flush/reset.
REQ-024 o_ready is a register-derived function of state only; no combinational path from i_ready to o_ready.
REQ-025 o_sum/o_cout hold stable while o_valid=1 and i_ready=0.
REQ-026 i_flush=1: next state EMPTY regardless of i_valid/i_ready; a beat offered in the flush cycle is discarded; flush takes priority over accept.
REQ-027 Outputs o_sum/o_cout are don't-care-free: when o_valid=0 they hold the last value (zero after reset).

Reset
REQ-028 i_rst=1 at an edge: state EMPTY, o_valid=0, o_ready=1 from the following cycle, o_sum=0, o_cout=0, both entries cleared.
REQ-029 Reset mid-operation discards all buffered beats; reset takes priority over flush, accept and deliver.
REQ-030 During the reset cycle, i_valid is ignored.

Structure
REQ-031 Shared package ks_pkg holds KS_WIDTH=24 and the state enum (EMPTY, HALF, FULL); WIDTH defaults to KS_WIDTH.
REQ-032 One combinational sub-module ks_sum (p_save, gk, c0 -> sum, cout) implements REQ-014/015; ks_sum_pipe instantiates it once on the input side and registers its result.

Verification
REQ-033 Add 0xFFFFFF+0x000001, c0=0: i_p_save=0xFFFFFE, i_gk=0xFFFFFF, held i_ready=1 -> next cycle o_valid=1, o_sum=0x000000, o_cout=1.
REQ-034 i_p_save=0x000003, i_gk=0x000000, i_c0=0 -> o_sum=0x000003, o_cout=0; same with i_c0=1 -> o_sum=0x000002, o_cout=0.
REQ-035 Backpressure: i_ready=0, send beats A,B -> state FULL, o_ready=0, o_sum=A stable; third beat C held upstream; raise i_ready -> A, B, C out in order, no loss.
REQ-036 Streaming: i_valid=1, i_ready=1 for 100 random beats -> one result per cycle, latency 1, results match a+b+c0 reference model.
REQ-037 Flush in FULL with i_valid=1 -> next cycle o_valid=0, o_ready=1, offered beat not delivered later.
REQ-038 Assert i_rst while FULL -> next cycle o_valid=0, o_ready=1, o_sum=0, o_cout=0; subsequent beat passes with latency 1.
